// File: rtl/count_sequencer.sv
// Run controller for a WIDTH-bit up counter: start/stop/pause FSM with programmable terminal value and round count.
// Latency: first increment one cycle after the start edge; a run of limit L and R rounds lasts R*(L+1) cycles to done.
// Backpressure: pause (level) freezes the counter in HOLD; stop aborts to IDLE from RUN or HOLD.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (0 = reset)
//   start      start request, sampled in IDLE only
//   stop       abort the run (RUN/HOLD), returns to IDLE with count and round_cnt cleared
//   pause      level, freezes the counter while high
//   limit      terminal count value, latched at the start edge
//   rounds     number of wraps before done, latched at start, 0 behaves as 1
//   count      current counter value
//   round_cnt  wraps completed in the current run
//   busy       high in RUN and HOLD
//   wrap       one-cycle pulse when count returns to 0 from the terminal value
//   done       one-cycle pulse when the final round completes
module count_sequencer #(
    parameter int WIDTH    = 3,
    parameter int ROUNDS_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic [WIDTH-1:0]    limit,
    input  logic [ROUNDS_W-1:0] rounds,
    output logic [WIDTH-1:0]    count,
    output logic [ROUNDS_W-1:0] round_cnt,
    output logic                busy,
    output logic                wrap,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    limit_q;
    logic [ROUNDS_W-1:0] rounds_q;

    // Value round_cnt takes if the current RUN cycle is a wrap cycle.
    logic [ROUNDS_W-1:0] round_nxt;
    assign round_nxt = round_cnt + ROUNDS_W'(1);

    // Every output is a register; busy is assigned together with the state
    // it describes so it always equals (state==RUN || state==HOLD).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            limit_q   <= '0;
            rounds_q  <= '0;
            count     <= '0;
            round_cnt <= '0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Pulses default low; only the wrap/done branches raise them.
            wrap <= 1'b0;
            done <= 1'b0;

            unique case (state)
                IDLE: begin
                    count     <= '0;
                    round_cnt <= '0;
                    // start outranks a simultaneous stop here; a stop still
                    // held next cycle is acted on from RUN.
                    if (start) begin
                        limit_q  <= limit;
                        rounds_q <= (rounds == '0) ? ROUNDS_W'(1) : rounds;
                        state    <= RUN;
                        busy     <= 1'b1;
                    end
                end

                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        count     <= '0;
                        round_cnt <= '0;
                    end else if (pause) begin
                        // A pause on the terminal cycle defers the wrap
                        // until after resume.
                        state <= HOLD;
                    end else if (count == limit_q) begin
                        count     <= '0;
                        wrap      <= 1'b1;
                        round_cnt <= round_nxt;
                        if (round_nxt == rounds_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        // Natural modulo-2^WIDTH increment; limit_q of all
                        // ones is caught by the compare above first.
                        count <= count + WIDTH'(1);
                    end
                end

                HOLD: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        count     <= '0;
                        round_cnt <= '0;
                    end else if (!pause) begin
                        // Re-entering RUN costs one cycle; counting resumes
                        // on the edge after this one.
                        state <= RUN;
                    end
                end

                DONE: begin
                    // Single-cycle state; round_cnt keeps its final value
                    // for this cycle and clears as IDLE is entered.
                    state     <= IDLE;
                    count     <= '0;
                    round_cnt <= '0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
